// File: rtl/gbc_pkg.sv
// Shared types for the Game Boy Color cartridge-bus arbiter: FSM states,
// Grant encoding and the width of the optional fairness counter.
package gbc_pkg;

  localparam int unsigned FairCntWidth = 8;

  typedef enum logic [2:0] {
    ARB_IDLE       = 3'd0,
    ARB_GRANT_CPU  = 3'd1,
    ARB_GRANT_HOST = 3'd2,
    ARB_WAIT_CPU   = 3'd3,
    ARB_WAIT_HOST  = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_CPU  = 2'd1,
    GRANT_HOST = 2'd2
  } grant_e;

  // Owner of the bus while the arbiter sits in a given state.
  function automatic grant_e grantOf(input arb_state_e s);
    case (s)
      ARB_GRANT_CPU, ARB_WAIT_CPU:   grantOf = GRANT_CPU;
      ARB_GRANT_HOST, ARB_WAIT_HOST: grantOf = GRANT_HOST;
      default:                       grantOf = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gbc_cart_arbiter.sv
// Two-initiator (CPU, save engine host) arbiter onto the cartridge bus, one
// transaction outstanding. Define GBC_CART_ARB_FAIRNESS_EN for host anti-starvation.
module gbc_cart_arbiter
  import gbc_pkg::*;
#(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned FairLimit = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ClkEn,

  input  logic                 CpuAccess,
  input  logic                 CpuWrite,
  input  logic [AddrWidth-1:0] CpuAddress,
  input  logic [7:0]           CpuDToTarget,
  output logic [7:0]           CpuDToInitiator,
  output logic                 CpuReady,
  output logic                 CpuDataReady,

  input  logic                 HostAccess,
  input  logic                 HostWrite,
  input  logic [AddrWidth-1:0] HostAddress,
  input  logic [7:0]           HostDToTarget,
  output logic [7:0]           HostDToInitiator,
  output logic                 HostReady,
  output logic                 HostDataReady,

  output logic                 TgtAccess,
  output logic                 TgtWrite,
  output logic [AddrWidth-1:0] TgtAddress,
  output logic [7:0]           TgtDToTarget,
  input  logic [7:0]           TgtDToInitiator,
  input  logic                 TgtReady,
  input  logic                 TgtDataReady,

  output logic [1:0]           Grant
);

  localparam logic [FairCntWidth-1:0] FairLimitCnt = FairCntWidth'(FairLimit);

  arb_state_e state_q, state_d;
  grant_e     grant_q, grant_d;
  logic [7:0] cpuRdata_q, hostRdata_q;

  logic cpuGranted, hostGranted, cpuWaiting, hostWaiting;
  logic ownerAccess, accept, complete, hostFirst;

  always_comb begin
    cpuGranted  = (state_q == ARB_GRANT_CPU);
    hostGranted = (state_q == ARB_GRANT_HOST);
    cpuWaiting  = (state_q == ARB_WAIT_CPU);
    hostWaiting = (state_q == ARB_WAIT_HOST);
  end

  // The request phase is a straight pass-through of the owner's signals.
  always_comb begin
    ownerAccess  = 1'b0;
    TgtWrite     = 1'b0;
    TgtAddress   = '0;
    TgtDToTarget = '0;
    if (cpuGranted) begin
      ownerAccess  = CpuAccess;
      TgtWrite     = CpuWrite;
      TgtAddress   = CpuAddress;
      TgtDToTarget = CpuDToTarget;
    end else if (hostGranted) begin
      ownerAccess  = HostAccess;
      TgtWrite     = HostWrite;
      TgtAddress   = HostAddress;
      TgtDToTarget = HostDToTarget;
    end
    TgtAccess = ownerAccess;
  end

  always_comb begin
    accept        = ClkEn & TgtAccess & TgtReady;
    complete      = ClkEn & TgtDataReady & (cpuWaiting | hostWaiting);
    CpuReady      = ClkEn & cpuGranted & TgtReady;
    HostReady     = ClkEn & hostGranted & TgtReady;
    CpuDataReady  = complete & cpuWaiting;
    HostDataReady = complete & hostWaiting;
  end

  // Read data is forwarded in the completion cycle and held afterwards.
  always_comb begin
    CpuDToInitiator  = CpuDataReady  ? TgtDToInitiator : cpuRdata_q;
    HostDToInitiator = HostDataReady ? TgtDToInitiator : hostRdata_q;
  end

  always_comb begin
    state_d = state_q;
    if (ClkEn) begin
      case (state_q)
        ARB_IDLE: begin
          if (HostAccess && hostFirst)  state_d = ARB_GRANT_HOST;
          else if (CpuAccess)           state_d = ARB_GRANT_CPU;
          else if (HostAccess)          state_d = ARB_GRANT_HOST;
        end
        ARB_GRANT_CPU, ARB_GRANT_HOST: begin
          if (!ownerAccess)   state_d = ARB_IDLE;
          else if (accept)    state_d = cpuGranted ? ARB_WAIT_CPU : ARB_WAIT_HOST;
        end
        ARB_WAIT_CPU, ARB_WAIT_HOST: begin
          if (complete)       state_d = ARB_IDLE;
        end
        default:              state_d = ARB_IDLE;
      endcase
    end
    grant_d = grantOf(state_d);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= GRANT_NONE;
      cpuRdata_q  <= '0;
      hostRdata_q <= '0;
    end else if (ClkEn) begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (CpuDataReady)  cpuRdata_q  <= TgtDToInitiator;
      if (HostDataReady) hostRdata_q <= TgtDToInitiator;
    end
  end

  assign Grant = grant_q;

`ifdef GBC_CART_ARB_FAIRNESS_EN
  logic [FairCntWidth-1:0] fairCnt_q, fairCnt_d;

  // Counts CPU grants taken while the host is kept waiting; saturates.
  always_comb begin
    fairCnt_d = fairCnt_q;
    if (ClkEn) begin
      if (!HostAccess || (state_q == ARB_IDLE && state_d == ARB_GRANT_HOST))
        fairCnt_d = '0;
      else if (state_q == ARB_IDLE && state_d == ARB_GRANT_CPU && fairCnt_q != '1)
        fairCnt_d = fairCnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      fairCnt_q <= '0;
    else if (ClkEn) fairCnt_q <= fairCnt_d;
  end

  assign hostFirst = (fairCnt_q >= FairLimitCnt);
`else
  logic unusedFairLimit;

  assign hostFirst       = 1'b0;
  assign unusedFairLimit = ^FairLimitCnt;
`endif

endmodule

// File: tb/tb_gbc_cart_arbiter.sv
// Scoreboard bench for gbc_cart_arbiter: auto-responding target model, expected
// read data queued at acceptance and popped on each DataReady.
module tb_gbc_cart_arbiter;
  import gbc_pkg::*;

  logic        Clk, Reset, ClkEn;
  logic        CpuAccess, CpuWrite, CpuReady, CpuDataReady;
  logic [15:0] CpuAddress;
  logic [7:0]  CpuDToTarget, CpuDToInitiator;
  logic        HostAccess, HostWrite, HostReady, HostDataReady;
  logic [15:0] HostAddress;
  logic [7:0]  HostDToTarget, HostDToInitiator;
  logic        TgtAccess, TgtWrite, TgtReady, TgtDataReady;
  logic [15:0] TgtAddress;
  logic [7:0]  TgtDToTarget, TgtDToInitiator;
  logic [1:0]  Grant;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] cpuExp[$];
  logic [7:0] hostExp[$];
  logic [1:0] grantLog[$];
  logic [1:0] prevGrant;
  logic [1:0] expOrder[5];

  int cpuRdyCnt, cpuDrCnt, hostRdyCnt, hostDrCnt, cpuAccCnt, hostAccCnt;
  int nonOwnerErr, tickNo, cpuDrTick, hostGrantTick, pend;
  bit autoTgt, cpuKeep, hostKeep;
  logic        tgtReadyVal;
  logic [7:0]  pendData;
  logic [15:0] lastTgtAddr;
  logic        lastTgtWrite;
  logic [7:0]  lastTgtData;

  gbc_cart_arbiter #(.AddrWidth(16), .FairLimit(3)) dut (
    .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn),
    .CpuAccess(CpuAccess), .CpuWrite(CpuWrite), .CpuAddress(CpuAddress),
    .CpuDToTarget(CpuDToTarget), .CpuDToInitiator(CpuDToInitiator),
    .CpuReady(CpuReady), .CpuDataReady(CpuDataReady),
    .HostAccess(HostAccess), .HostWrite(HostWrite), .HostAddress(HostAddress),
    .HostDToTarget(HostDToTarget), .HostDToInitiator(HostDToInitiator),
    .HostReady(HostReady), .HostDataReady(HostDataReady),
    .TgtAccess(TgtAccess), .TgtWrite(TgtWrite), .TgtAddress(TgtAddress),
    .TgtDToTarget(TgtDToTarget), .TgtDToInitiator(TgtDToInitiator),
    .TgtReady(TgtReady), .TgtDataReady(TgtDataReady),
    .Grant(Grant)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Read data the target model returns for an address.
  function automatic logic [7:0] tgtFn(input logic [15:0] a);
    return a[7:0] ^ 8'h79;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearCounters();
    cpuRdyCnt = 0; cpuDrCnt = 0; hostRdyCnt = 0; hostDrCnt = 0;
    cpuAccCnt = 0; hostAccCnt = 0;
    grantLog.delete();
  endtask

  // One clock: monitor/scoreboard on the falling edge, stimulus and target after the rising edge.
  task automatic applyStimulus();
    logic accept, cpuAcc, hostAcc, drSeen;
    @(negedge Clk);
    tickNo++;
    accept  = ClkEn && TgtAccess && TgtReady;
    cpuAcc  = accept && CpuReady;
    hostAcc = accept && HostReady;
    if (accept) begin
      lastTgtAddr  = TgtAddress;
      lastTgtWrite = TgtWrite;
      lastTgtData  = TgtDToTarget;
    end
    if (cpuAcc)  begin cpuAccCnt++;  cpuExp.push_back(tgtFn(CpuAddress));   end
    if (hostAcc) begin hostAccCnt++; hostExp.push_back(tgtFn(HostAddress)); end
    if (CpuReady)  cpuRdyCnt++;
    if (HostReady) hostRdyCnt++;
    if ((CpuReady || CpuDataReady) && Grant != 2'd1)   nonOwnerErr++;
    if ((HostReady || HostDataReady) && Grant != 2'd2) nonOwnerErr++;
    if (CpuDataReady) begin
      cpuDrCnt++;
      cpuDrTick = tickNo;
      if (cpuExp.size() == 0) checkOutput("cpuUnexpectedDR", 1, 0);
      else checkOutput("cpuRdData", 32'(CpuDToInitiator), 32'(cpuExp.pop_front()));
    end
    if (HostDataReady) begin
      hostDrCnt++;
      if (hostExp.size() == 0) checkOutput("hostUnexpectedDR", 1, 0);
      else checkOutput("hostRdData", 32'(HostDToInitiator), 32'(hostExp.pop_front()));
    end
    if (Grant != prevGrant) begin
      if (Grant != 2'd0) begin
        grantLog.push_back(Grant);
        if (Grant == 2'd2) hostGrantTick = tickNo;
      end
      prevGrant = Grant;
    end
    drSeen = ClkEn && TgtDataReady;
    @(posedge Clk);
    #1;
    if (cpuAcc) begin
      if (cpuKeep) CpuAddress = CpuAddress + 16'd1;
      else CpuAccess = 1'b0;
    end
    if (hostAcc) begin
      if (hostKeep) HostAddress = HostAddress + 16'd1;
      else HostAccess = 1'b0;
    end
    if (autoTgt) begin
      TgtReady = tgtReadyVal;
      if (drSeen) TgtDataReady = 1'b0;
      if (accept) begin
        pend     = 3;
        pendData = tgtFn(lastTgtAddr);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          TgtDataReady    = 1'b1;
          TgtDToInitiator = pendData;
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; ClkEn = 1'b1;
    CpuAccess = 1'b0; CpuWrite = 1'b0; CpuAddress = '0; CpuDToTarget = '0;
    HostAccess = 1'b0; HostWrite = 1'b0; HostAddress = '0; HostDToTarget = '0;
    TgtReady = 1'b1; TgtDataReady = 1'b0; TgtDToInitiator = '0;
    autoTgt = 1'b1; cpuKeep = 1'b0; hostKeep = 1'b0; tgtReadyVal = 1'b1;
    pend = 0; prevGrant = 2'd0; nonOwnerErr = 0; tickNo = 0;
    cpuDrTick = 0; hostGrantTick = 0;
    clearCounters();
    #2;
    checkOutput("rstGrant", 32'(Grant), 0);
    checkOutput("rstTgtAccess", 32'(TgtAccess), 0);
    checkOutput("rstTgtWrite", 32'(TgtWrite), 0);
    checkOutput("rstTgtAddr", 32'(TgtAddress), 0);
    checkOutput("rstReadies", 32'({CpuReady, CpuDataReady, HostReady, HostDataReady}), 0);
    checkOutput("rstRdata", 32'({CpuDToInitiator, HostDToInitiator}), 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Lone CPU read
    clearCounters();
    CpuWrite = 1'b0; CpuAddress = 16'h4123; CpuAccess = 1'b1;
    applyStimulus();
    checkOutput("cpuLatencyTgtAccess", 32'(TgtAccess), 1);
    checkOutput("cpuLatencyTgtAddr", 32'(TgtAddress), 32'h4123);
    for (int i = 0; i < 20 && cpuDrCnt == 0; i++) applyStimulus();
    checkOutput("cpuRdDone", cpuDrCnt, 1);
    checkOutput("cpuRdyCycles", cpuRdyCnt, 1);
    applyStimulus();
    checkOutput("cpuGrantIdle", 32'(Grant), 0);
    checkOutput("cpuRdHold", 32'(CpuDToInitiator), 32'h5A);
    checkOutput("cpuDrOnce", cpuDrCnt, 1);

    // Simultaneous requests: CPU first, host after one idle cycle
    clearCounters();
    CpuAddress = 16'h0102; HostAddress = 16'h8003; HostWrite = 1'b0;
    CpuAccess = 1'b1; HostAccess = 1'b1;
    for (int i = 0; i < 60 && hostDrCnt == 0; i++) applyStimulus();
    checkOutput("tieHostDone", hostDrCnt, 1);
    checkOutput("tieFirstGrant", grantLog.size() > 0 ? 32'(grantLog[0]) : 0, 1);
    checkOutput("tieSecondGrant", grantLog.size() > 1 ? 32'(grantLog[1]) : 0, 2);
    checkOutput("tieIdleGap", hostGrantTick - cpuDrTick, 2);
    checkOutput("tieNonOwner", nonOwnerErr, 0);

    // Continuous contention
    clearCounters();
`ifdef GBC_CART_ARB_FAIRNESS_EN
    expOrder = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
`else
    expOrder = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
`endif
    cpuKeep = 1'b1; hostKeep = 1'b1;
    CpuAddress = 16'h2000; HostAddress = 16'h9000;
    CpuAccess = 1'b1; HostAccess = 1'b1;
    for (int i = 0; i < 400 && grantLog.size() < 5; i++) applyStimulus();
    cpuKeep = 1'b0; hostKeep = 1'b0; CpuAccess = 1'b0; HostAccess = 1'b0;
    repeat (10) applyStimulus();
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("grantOrder%0d", i), grantLog.size() > i ? 32'(grantLog[i]) : 0, 32'(expOrder[i]));
    checkOutput("sbCpuDrained", cpuExp.size(), 0);
    checkOutput("sbHostDrained", hostExp.size(), 0);

    // Host write interrupted by reset
    clearCounters();
    HostWrite = 1'b1; HostAddress = 16'hA010; HostDToTarget = 8'h77; HostAccess = 1'b1;
    for (int i = 0; i < 20 && hostAccCnt == 0; i++) applyStimulus();
    checkOutput("hostWrAccepted", hostAccCnt, 1);
    checkOutput("hostWrTgtWrite", 32'(lastTgtWrite), 1);
    checkOutput("hostWrTgtAddr", 32'(lastTgtAddr), 32'hA010);
    checkOutput("hostWrTgtData", 32'(lastTgtData), 32'h77);
    applyStimulus();
    Reset = 1'b1;
    hostExp.delete();
    #1;
    checkOutput("midRstGrant", 32'(Grant), 0);
    checkOutput("midRstReadies", 32'({HostReady, HostDataReady, TgtAccess, TgtWrite}), 0);
    checkOutput("midRstRdata", 32'(HostDToInitiator), 0);
    applyStimulus();
    Reset = 1'b0; HostWrite = 1'b0;
    repeat (6) applyStimulus();
    checkOutput("strayNoHostDR", hostDrCnt, 0);

    // CPU aborts while the target stalls
    clearCounters();
    tgtReadyVal = 1'b0; TgtReady = 1'b0;
    CpuAddress = 16'h3001; CpuAccess = 1'b1;
    applyStimulus();
    checkOutput("abortGrantCpu", 32'(Grant), 1);
    checkOutput("abortNoReady", 32'(CpuReady), 0);
    checkOutput("abortTgtAccess", 32'(TgtAccess), 1);
    applyStimulus();
    CpuAccess = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("abortIdle", 32'(Grant), 0);
    repeat (5) applyStimulus();
    checkOutput("abortNoAccept", cpuAccCnt, 0);
    checkOutput("abortNoDR", cpuDrCnt, 0);
    tgtReadyVal = 1'b1; TgtReady = 1'b1;

    // ClkEn gating of completion, target driven by hand
    clearCounters();
    autoTgt = 1'b0;
    CpuWrite = 1'b0; CpuAddress = 16'h1234; CpuAccess = 1'b1;
    for (int i = 0; i < 10 && cpuAccCnt == 0; i++) applyStimulus();
    checkOutput("gateAccepted", cpuAccCnt, 1);
    applyStimulus();
    ClkEn = 1'b0; TgtDataReady = 1'b1; TgtDToInitiator = 8'hC3;
    #1;
    checkOutput("gateNoDRComb", 32'(CpuDataReady), 0);
    repeat (2) applyStimulus();
    checkOutput("gateFrozenGrant", 32'(Grant), 1);
    ClkEn = 1'b1; TgtDataReady = 1'b0;
    applyStimulus();
    checkOutput("gateNoEarlyDR", cpuDrCnt, 0);
    checkOutput("gateStillWait", 32'(Grant), 1);
    TgtDataReady = 1'b1; TgtDToInitiator = 8'h4D;
    #1;
    checkOutput("gateDRComb", 32'(CpuDataReady), 1);
    applyStimulus();
    TgtDataReady = 1'b0;
    checkOutput("gateDone", cpuDrCnt, 1);
    checkOutput("gateIdle", 32'(Grant), 0);
    checkOutput("gateHold", 32'(CpuDToInitiator), 32'h4D);
    autoTgt = 1'b1;

    repeat (3) applyStimulus();
    checkOutput("finalNonOwner", nonOwnerErr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gbc_cart_arbiter.md
GBC_CART_ARBITER -- requirements
Module: gbc_cart_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AddrWidth, 16, address width of all three ports.
REQ-002 FairLimit, 8, consecutive CPU grants tolerated while the host waits (range 1..255).
REQ-003 The design SHALL have one clock, Clk, and an asynchronous, active-high reset, Reset.
REQ-004 Clk  in  1  system clock.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 ClkEn  in  1  clock enable; all state and handshakes advance only when high.
REQ-007 CpuAccess  in  1  CPU request valid.
REQ-008 CpuWrite  in  1  1 = write, 0 = read.
REQ-009 CpuAddress  in  AddrWidth  request address.
REQ-010 CpuDToTarget  in  8  write data.
REQ-011 CpuDToInitiator  out  8  read data.
REQ-012 CpuReady  out  1  request accepted.
REQ-013 CpuDataReady  out  1  transaction complete; read data valid.
REQ-014 Host port (HostAccess, HostWrite, HostAddress, HostDToTarget, HostDToInitiator, HostReady, HostDataReady): same directions, widths and meaning as the Cpu port; driven by the save-RAM/save-state engine.
REQ-015 Tgt port (TgtAccess, TgtWrite, TgtAddress, TgtDToTarget out; TgtDToInitiator, TgtReady, TgtDataReady in): faces the cartridge/mapper bus.
REQ-016 Grant  out  2  current owner: 0 none, 1 CPU, 2 Host.

Function
REQ-017 FSM states: IDLE, GRANT_CPU, GRANT_HOST, WAIT_CPU, WAIT_HOST. At most one transaction outstanding.
REQ-018 IDLE: on a ClkEn cycle with CpuAccess, go to GRANT_CPU; else if HostAccess, go to GRANT_HOST. CPU wins ties unless REQ-027 applies.
REQ-019 GRANT_x: TgtAccess, TgtWrite, TgtAddress and TgtDToTarget SHALL equal the owner's inputs. xReady = TgtReady. Acceptance = a ClkEn cycle with TgtAccess and TgtReady high; then go to WAIT_x.
REQ-020 GRANT_x with owner Access low before acceptance: abort and return to IDLE; no Tgt transaction occurs.
REQ-021 WAIT_x: TgtAccess = 0. On a ClkEn cycle with TgtDataReady high, xDataReady = 1 combinationally in the same cycle and xDToInitiator = TgtDToInitiator; next state IDLE. Writes also complete via TgtDataReady.
REQ-022 The non-owner's Ready and DataReady SHALL be 0 at all times. Each DToInitiator SHALL hold its last delivered value.
REQ-023 Minimum latency: request in IDLE to Tgt presentation is 1 cycle. Back-to-back grants SHALL pass through IDLE (one idle ClkEn cycle).
REQ-024 ClkEn low: state, counter and held data frozen; all Ready/DataReady outputs = 0.
REQ-025 TgtDataReady outside WAIT_x SHALL be ignored.

Reset
REQ-026 On Reset: state IDLE, Grant 0, TgtAccess/TgtWrite 0, TgtAddress/TgtDToTarget 0, all Ready/DataReady 0, DToInitiator 0, fairness counter 0. A mid-transaction reset discards the outstanding response.

Configuration
REQ-027 With GBC_CART_ARB_FAIRNESS_EN defined: an 8-bit counter increments on each CPU grant taken while HostAccess is high. It clears on a host grant or when HostAccess is low. When the counter reaches FairLimit, the next IDLE arbitration grants the host even if CpuAccess is high.
REQ-028 Without GBC_CART_ARB_FAIRNESS_EN: strict CPU priority; no counter logic is generated; FairLimit is ignored.

Structure
REQ-029 The state enum and the Grant encoding (GRANT_NONE/CPU/HOST) SHALL live in shared package gbc_pkg.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 CPU read 0x4123 alone; Tgt Ready at acceptance, DataReady 3 cycles later with 0x5A -> CpuReady 1 cycle, CpuDataReady 1 cycle with CpuDToInitiator = 0x5A; Grant returns to 0.
REQ-032 CpuAccess and HostAccess both raised in the same cycle -> CPU granted first. Host granted after CPU DataReady plus one IDLE cycle; HostReady stays 0 throughout the CPU transaction.
REQ-033 FAIRNESS_EN, FairLimit = 3, CPU and Host continuously requesting -> grant order CPU, CPU, CPU, HOST, CPU... Without the macro -> CPU only, host starved.
REQ-034 Host write 0xA010 = 0x77 accepted; Reset asserted before TgtDataReady -> all outputs reset immediately; a later TgtDataReady produces no HostDataReady.
REQ-035 CPU drops CpuAccess while in GRANT_CPU with TgtReady = 0 -> return to IDLE; no acceptance and no CpuDataReady.
REQ-036 ClkEn toggling 1-0-1 during WAIT_CPU with TgtDataReady high only while ClkEn = 0 -> no completion; completion occurs on the first ClkEn = 1 cycle with TgtDataReady.
